qupls4_fu_occupancy_scheduler: RTL and testbench
================================================

Name: qupls4_fu_occupancy_scheduler

Overview:
- Generates the per-functional-unit busy[15:0] vector consumed by the instruction dispatcher.
- Tracks occupancy of non-pipelined or multicycle units (divider/sqrt, trig, etc.) with per-unit countdown counters loaded from a programmable latency table.
- Merges occupancy with reservation-station-full indications, and supports early completion, pipeline flush and protocol-error detection.
- Sits between the dispatcher's registered dispatch outputs and the functional-unit / reservation-station logic.

Parameters:
- DISPATCH_COUNT, 6, number of dispatch slots presented per cycle.
- NFU, 16, number of functional-unit ids (funcunit field is 4 bits).
- CNTW, 7, width of each occupancy counter and latency-table entry.
- DIV_LAT, 40, reset latency for unit 3 (div/sqrt).
- TRIG_LAT, 24, reset latency for unit 6 (trig).
- CANCEL_MASK, 16'h0048, units whose occupancy is cancelled by flush (bits 3 and 6).

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- disp_v  in  DISPATCH_COUNT  dispatch slot valid (from the dispatcher's rob_dispatched_v_o)
- disp_fu  in  DISPATCH_COUNT*4  funcunit id per slot
- fu_done  in  NFU  unit finished early (variable-latency completion), one-cycle pulse
- rs_full  in  NFU  reservation station of unit cannot accept
- flush  in  1  pipeline flush/stomp of all speculative work
- cfg_we  in  1  latency table write strobe
- cfg_fu  in  4  latency table index
- cfg_lat  in  CNTW  latency value; 0 = fully pipelined
- busy_o  out  NFU  registered busy vector to the dispatcher
- err_o  out  NFU  sticky protocol-error flag per unit
- stat_fu  in  4  statistics select
- stat_cnt  out  16  busy-cycle count of selected unit

Behaviour:
- Reset:
  - cnt[*]=0, busy_o=0, err_o=0, stat counters=0.
  - lat[3]=DIV_LAT, lat[6]=TRIG_LAT, all other lat entries=0.
- Per unit f, the counter is a two-state machine:
  - IDLE (cnt==0) -> OCC on accepted dispatch with lat[f]!=0; cnt loaded with lat[f].
  - OCC decrements by 1 per cycle; returns to IDLE when cnt reaches 0, on fu_done[f], or on flush when CANCEL_MASK[f]=1.
- Priority per unit, highest first:
  - reset
  - dispatch load
  - flush cancel
  - fu_done clear
  - decrement
- A dispatch coincident with flush is still loaded; the dispatcher stomps the uop itself.
- busy_o[f] <= (next_cnt[f]!=0) | rs_full[f], registered.
  - Dispatch in cycle N to a unit with lat=L>0 raises busy_o at edge N+1.
  - busy_o stays high for exactly L cycles if undisturbed.
  - L=1 yields a single busy cycle.
- lat[f]=0: dispatch has no occupancy effect; busy_o[f] follows rs_full[f] only, delayed one cycle.
- Multiple slots naming the same unit in one cycle:
  - If lat!=0, the lowest slot is accepted and err_o[f] is set.
  - If lat==0, this is legal (pipelined units, SAU pair handled by distinct ids).
- Dispatch to a unit whose cnt!=0: counter reloads with lat[f] and err_o[f] is set (sticky until rst).
- Config write:
  - lat[cfg_fu] <= cfg_lat at the edge.
  - A same-cycle dispatch to that unit uses the old value.
  - A running counter is not modified.
- Counter arithmetic: unsigned CNTW bits, no wrap; decrement is gated at 0.
- fu_done on an idle unit is ignored with no error.
- Reset mid-occupancy clears everything in one cycle; busy_o is 0 the following cycle.

Optional Feature:
- QUPLS4_FU_BUSY_STATS_EN
  - Defined: per-unit 16-bit saturating counters increment each cycle busy_o[f]=1; stat_cnt = counter[stat_fu], registered, 1-cycle read latency; counters cleared only by rst.
  - Undefined: no counters are built; stat_cnt tied to 0.

Test Plan:
- Reset then idle: busy_o=16'h0000, err_o=0; lat[3] reads back via behaviour as 40-cycle occupancy.
- Dispatch fu 3 in cycle 10: busy_o[3]=1 in cycles 11..50, 0 at cycle 51; other bits 0.
- Dispatch fu 3, then fu_done[3] in cycle 15: busy_o[3] falls at cycle 16; dispatch fu 6 with flush asserted in the same cycle: busy_o[6] still rises for 24 cycles.
- cfg_we fu=2 lat=5 in the same cycle as a dispatch to fu 2: no busy from that dispatch; next dispatch to fu 2 gives 5 busy cycles.
- Slots 0 and 4 both fu 3 in one cycle: one 40-cycle occupancy, err_o[3]=1; redispatch while busy reloads to 40, err stays 1 until rst.
- rs_full[8]=1 for 3 cycles with lat[8]=0: busy_o[8] high for exactly those 3 cycles, delayed by 1; with STATS_EN and stat_fu=8, stat_cnt=3.

Source files
------------

// File: rtl/qupls4_fu_occupancy_scheduler_if.sv
// Dispatch-side bus between the dispatcher and the FU occupancy scheduler:
// dispatched slots flow in, the registered per-unit busy vector flows back.
interface qupls4_fu_occupancy_scheduler_if #(
   parameter int unsigned DISPATCH_COUNT = 6,
   parameter int unsigned NFU = 16
);
   logic [DISPATCH_COUNT-1:0]   disp_v;
   logic [DISPATCH_COUNT*4-1:0] disp_fu;
   logic [NFU-1:0]              busy_o;

   modport master (output disp_v, output disp_fu, input busy_o);
   modport slave (input disp_v, input disp_fu, output busy_o);
endinterface

// File: rtl/qupls4_fu_occupancy_scheduler.sv
// Per-functional-unit occupancy counters producing the dispatcher's busy vector.
// Optional QUPLS4_FU_BUSY_STATS_EN builds per-unit busy-cycle statistics counters.
module qupls4_fu_occupancy_scheduler #(
   parameter int unsigned DISPATCH_COUNT = 6,
   parameter int unsigned NFU = 16,
   parameter int unsigned CNTW = 7,
   parameter int unsigned DIV_LAT = 40,
   parameter int unsigned TRIG_LAT = 24,
   parameter logic [NFU-1:0] CANCEL_MASK = 'h0048
) (
   input  logic                 clk,
   input  logic                 rst,
   qupls4_fu_occupancy_scheduler_if.slave dif,
   input  logic [NFU-1:0]       fu_done,
   input  logic [NFU-1:0]       rs_full,
   input  logic                 flush,
   input  logic                 cfg_we,
   input  logic [3:0]           cfg_fu,
   input  logic [CNTW-1:0]      cfg_lat,
   output logic [NFU-1:0]       err_o,
   input  logic [3:0]           stat_fu,
   output logic [15:0]          stat_cnt
);

   logic [CNTW-1:0] cnt_q [NFU];
   logic [CNTW-1:0] cnt_d [NFU];
   logic [CNTW-1:0] lat_q [NFU];
   logic [NFU-1:0]  hit, multi, err_d, busy_d, busy_q, err_q;

   assign dif.busy_o = busy_q;
   assign err_o      = err_q;

   always_comb begin
      logic [3:0] fu;
      fu    = '0;
      hit   = '0;
      multi = '0;
      for (int s = 0; s < DISPATCH_COUNT; s++) begin
         if (dif.disp_v[s]) begin
            fu = dif.disp_fu[s*4 +: 4];
            if (hit[fu]) multi[fu] = 1'b1;
            hit[fu] = 1'b1;
         end
      end
      for (int f = 0; f < NFU; f++) begin
         // Every same-unit slot carries the same load value, so the lowest slot wins implicitly.
         if (hit[f])
            cnt_d[f] = lat_q[f];
         else if (flush && CANCEL_MASK[f])
            cnt_d[f] = '0;
         else if (fu_done[f])
            cnt_d[f] = '0;
         else if (cnt_q[f] != '0)
            cnt_d[f] = cnt_q[f] - CNTW'(1);
         else
            cnt_d[f] = '0;
         err_d[f]  = hit[f] && ((cnt_q[f] != '0) || (multi[f] && (lat_q[f] != '0)));
         busy_d[f] = (cnt_d[f] != '0) || rs_full[f];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int f = 0; f < NFU; f++) begin
            cnt_q[f] <= '0;
            if (f == 3)
               lat_q[f] <= CNTW'(DIV_LAT);
            else if (f == 6)
               lat_q[f] <= CNTW'(TRIG_LAT);
            else
               lat_q[f] <= '0;
         end
         busy_q <= '0;
         err_q  <= '0;
      end else begin
         for (int f = 0; f < NFU; f++) cnt_q[f] <= cnt_d[f];
         busy_q <= busy_d;
         err_q  <= err_q | err_d;
         // Same-cycle dispatch already sampled the old entry through cnt_d.
         if (cfg_we) lat_q[cfg_fu] <= cfg_lat;
      end
   end

`ifdef QUPLS4_FU_BUSY_STATS_EN
   logic [15:0] stat_q [NFU];
   logic [15:0] stat_rd_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int f = 0; f < NFU; f++) stat_q[f] <= '0;
         stat_rd_q <= '0;
      end else begin
         for (int f = 0; f < NFU; f++)
            if (busy_q[f] && (stat_q[f] != 16'hFFFF)) stat_q[f] <= stat_q[f] + 16'd1;
         stat_rd_q <= stat_q[stat_fu];
      end
   end

   assign stat_cnt = stat_rd_q;
`else
   logic unused_stat_fu;
   assign unused_stat_fu = ^stat_fu;
   assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_qupls4_fu_occupancy_scheduler.sv
// Bench for qupls4_fu_occupancy_scheduler: directed vector table, multi-cycle sequences,
// and randomized traffic against a behavioural occupancy model.
module tb_qupls4_fu_occupancy_scheduler;
   localparam int DC = 6;
   localparam int NFU = 16;
   localparam int CNTW = 7;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   qupls4_fu_occupancy_scheduler_if #(.DISPATCH_COUNT(DC), .NFU(NFU)) dif ();

   logic [NFU-1:0]  fu_done, rs_full, err_o;
   logic            flush, cfg_we;
   logic [3:0]      cfg_fu, stat_fu;
   logic [CNTW-1:0] cfg_lat;
   logic [15:0]     stat_cnt;

   qupls4_fu_occupancy_scheduler dut (
      .clk(clk), .rst(rst), .dif(dif), .fu_done(fu_done), .rs_full(rs_full), .flush(flush),
      .cfg_we(cfg_we), .cfg_fu(cfg_fu), .cfg_lat(cfg_lat), .err_o(err_o), .stat_fu(stat_fu),
      .stat_cnt(stat_cnt)
   );

   int n_cmp = 0;
   int n_fail = 0;

   // Behavioural model: remaining occupancy cycles per unit, in plain integers.
   int          occ [NFU];
   int          mlat [NFU];
   int          mstat [NFU];
   int          mstat_rd;
   logic [15:0] merr, mbusy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_edge();
      int n [NFU];
      if (rst) begin
         for (int f = 0; f < NFU; f++) begin
            occ[f] = 0;
            mstat[f] = 0;
            mlat[f] = (f == 3) ? 40 : (f == 6) ? 24 : 0;
         end
         merr = '0;
         mbusy = '0;
         mstat_rd = 0;
         return;
      end
      mstat_rd = mstat[stat_fu];
      for (int f = 0; f < NFU; f++) begin
         if (mbusy[f] && mstat[f] < 65535) mstat[f]++;
         n[f] = 0;
      end
      for (int s = 0; s < DC; s++)
         if (dif.disp_v[s]) n[int'(dif.disp_fu[s*4 +: 4])]++;
      for (int f = 0; f < NFU; f++) begin
         if (n[f] > 0) begin
            if (occ[f] > 0 || (n[f] > 1 && mlat[f] > 0)) merr[f] = 1'b1;
            occ[f] = mlat[f];
         end else if (flush && (f == 3 || f == 6)) occ[f] = 0;
         else if (fu_done[f]) occ[f] = 0;
         else if (occ[f] > 0) occ[f]--;
         mbusy[f] = (occ[f] > 0) || rs_full[f];
      end
      if (cfg_we) mlat[int'(cfg_fu)] = int'(cfg_lat);
   endfunction

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("model_busy", 32'(dif.busy_o), 32'(mbusy));
      check("model_err", 32'(err_o), 32'(merr));
`ifdef QUPLS4_FU_BUSY_STATS_EN
      check("model_stat", 32'(stat_cnt), 32'(mstat_rd));
`else
      check("model_stat", 32'(stat_cnt), 32'd0);
`endif
   endtask

   task automatic idle_inputs();
      dif.disp_v = '0;
      dif.disp_fu = '0;
      fu_done = '0;
      rs_full = '0;
      flush = 1'b0;
      cfg_we = 1'b0;
      cfg_fu = '0;
      cfg_lat = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Counts consecutive sampled cycles with busy_o[f] high, bounded.
   task automatic count_busy(input int f, input int bound, output int n);
      n = 0;
      while (dif.busy_o[f] && n < bound) begin
         n++;
         step();
      end
   endtask

   typedef struct {
      logic [DC-1:0]   v;
      logic [DC*4-1:0] fu;
      logic [NFU-1:0]  done;
      logic [NFU-1:0]  full;
      logic            fl;
      logic [NFU-1:0]  exp_busy;
      logic [NFU-1:0]  exp_err;
   } vec_t;

   vec_t vt [9];
   int   nb;

   initial begin
      vt[0] = '{6'b000001, 24'h000003, 16'h0000, 16'h0000, 1'b0, 16'h0008, 16'h0000};
      vt[1] = '{6'b000000, 24'h000000, 16'h0000, 16'h0002, 1'b0, 16'h000A, 16'h0000};
      vt[2] = '{6'b000010, 24'h000060, 16'h0000, 16'h0000, 1'b0, 16'h0048, 16'h0000};
      vt[3] = '{6'b000000, 24'h000000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000};
      vt[4] = '{6'b000000, 24'h000000, 16'h0020, 16'h0000, 1'b0, 16'h0000, 16'h0000};
      vt[5] = '{6'b001100, 24'h008800, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
      vt[6] = '{6'b100000, 24'h600000, 16'h0000, 16'h0000, 1'b0, 16'h0040, 16'h0000};
      vt[7] = '{6'b000001, 24'h000006, 16'h0000, 16'h0000, 1'b0, 16'h0040, 16'h0040};
      vt[8] = '{6'b000000, 24'h000000, 16'h0040, 16'h0000, 1'b0, 16'h0000, 16'h0040};

      stat_fu = '0;
      do_reset();
      for (int i = 0; i < 3; i++) step();
      check("reset_busy", 32'(dif.busy_o), 32'h0);
      check("reset_err", 32'(err_o), 32'h0);

      // Division occupancy runs for exactly the reset latency of 40.
      dif.disp_v = 6'b000001;
      dif.disp_fu = 24'h000003;
      step();
      idle_inputs();
      check("div_rise", 32'(dif.busy_o), 32'h0008);
      count_busy(3, 60, nb);
      check("div_len", 32'(nb), 32'd40);
      check("div_fall", 32'(dif.busy_o), 32'h0);

      // Early completion, then a flush-coincident dispatch to trig still loads.
      dif.disp_v = 6'b000001;
      dif.disp_fu = 24'h000003;
      step();
      idle_inputs();
      for (int i = 0; i < 4; i++) step();
      fu_done[3] = 1'b1;
      step();
      fu_done = '0;
      check("done_clear", 32'(dif.busy_o[3]), 32'd0);
      dif.disp_v = 6'b000001;
      dif.disp_fu = 24'h000006;
      flush = 1'b1;
      step();
      idle_inputs();
      count_busy(6, 40, nb);
      check("trig_flush_len", 32'(nb), 32'd24);

      // Latency write coincident with dispatch uses the old (zero) entry.
      cfg_we = 1'b1;
      cfg_fu = 4'd2;
      cfg_lat = 7'd5;
      dif.disp_v = 6'b000001;
      dif.disp_fu = 24'h000002;
      step();
      idle_inputs();
      check("cfg_old_lat", 32'(dif.busy_o), 32'h0);
      dif.disp_v = 6'b000100;
      dif.disp_fu = 24'h000200;
      step();
      idle_inputs();
      count_busy(2, 10, nb);
      check("cfg_new_len", 32'(nb), 32'd5);

      // Duplicate slots, then a reload while busy; error is sticky until reset.
      dif.disp_v = 6'b010001;
      dif.disp_fu = 24'h030003;
      step();
      idle_inputs();
      check("dup_err", 32'(err_o), 32'h0008);
      for (int i = 0; i < 9; i++) step();
      dif.disp_v = 6'b000100;
      dif.disp_fu = 24'h000300;
      step();
      idle_inputs();
      count_busy(3, 60, nb);
      check("reload_len", 32'(nb), 32'd40);
      check("err_sticky", 32'(err_o), 32'h0008);
      do_reset();
      check("rst_err", 32'(err_o), 32'h0);
      check("rst_busy", 32'(dif.busy_o), 32'h0);

      // Reservation-station-full on a pipelined unit.
      nb = 0;
      for (int i = 0; i < 6; i++) begin
         rs_full[8] = (i < 3);
         step();
         if (dif.busy_o[8]) nb++;
         if (i == 0) check("rsfull_rise", 32'(dif.busy_o), 32'h0100);
         if (i == 3) check("rsfull_fall", 32'(dif.busy_o), 32'h0);
      end
      check("rsfull_len", 32'(nb), 32'd3);
      stat_fu = 4'd8;
      step();
      step();
`ifdef QUPLS4_FU_BUSY_STATS_EN
      check("stat_fu8", 32'(stat_cnt), 32'd3);
`else
      check("stat_off", 32'(stat_cnt), 32'd0);
`endif

      do_reset();
      foreach (vt[i]) begin
         dif.disp_v = vt[i].v;
         dif.disp_fu = vt[i].fu;
         fu_done = vt[i].done;
         rs_full = vt[i].full;
         flush = vt[i].fl;
         step();
         check($sformatf("vec%0d_busy", i), 32'(dif.busy_o), 32'(vt[i].exp_busy));
         check($sformatf("vec%0d_err", i), 32'(err_o), 32'(vt[i].exp_err));
      end

      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] pick [4];
         pick[0] = 4'd2;
         pick[1] = 4'd3;
         pick[2] = 4'd6;
         pick[3] = 4'd9;
         for (int s = 0; s < DC; s++) begin
            dif.disp_v[s] = ($urandom_range(0, 7) == 0);
            dif.disp_fu[s*4 +: 4] = $urandom_range(0, 1) ? pick[$urandom_range(0, 3)]
                                                          : 4'($urandom_range(0, 15));
         end
         for (int f = 0; f < NFU; f++) begin
            fu_done[f] = ($urandom_range(0, 29) == 0);
            rs_full[f] = ($urandom_range(0, 9) == 0);
         end
         flush = ($urandom_range(0, 39) == 0);
         cfg_we = ($urandom_range(0, 19) == 0);
         cfg_fu = $urandom_range(0, 1) ? pick[$urandom_range(0, 3)] : 4'($urandom_range(0, 15));
         cfg_lat = 7'($urandom_range(0, 12));
         stat_fu = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
